// File: rtl/ex_mem_skid_reg.sv
// ex_mem_skid_reg
//
// Execute-to-Memory pipeline register with a one-entry skid buffer. The
// block carries full throughput (one beat per cycle) when Memory is ready.
// It absorbs one extra beat when Memory stalls. ReadyE is decoded from
// registered state only, so there is no combinational ready path from
// Memory back to Execute.
//
// Parameters
//   XLEN  width of ALU result, store data and PC+4 fields
//   RW    destination register index width
//   CW    control bundle width (RegWrite, FPRegWrite, MemWrite, ResultSrc)
//   SCW   stall counter width
//
// Ports
//   clk                                   rising-edge clock
//   reset                                 asynchronous active-high reset
//   ValidE / ReadyE                       Execute-side handshake
//   ALUResultE, WriteDataE, PCPlus4E,
//   RdE, CtrlE                            Execute-side payload
//   FlushM                                synchronous squash of held beats
//   ValidM / ReadyM                       Memory-side handshake
//   ALUResultM, WriteDataM, PCPlus4M,
//   RdM, CtrlM                            Memory-side payload (main entry)
//   CountM                                occupancy 0..2 (equals FSM state)
//   StallCntM                             saturating back-pressure counter
module ex_mem_skid_reg #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RW   = 5,
  parameter int unsigned CW   = 4,
  parameter int unsigned SCW  = 16
) (
  input  logic            clk,
  input  logic            reset,
  // Execute side
  input  logic            ValidE,
  output logic            ReadyE,
  input  logic [XLEN-1:0] ALUResultE,
  input  logic [XLEN-1:0] WriteDataE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [RW-1:0]   RdE,
  input  logic [CW-1:0]   CtrlE,
  // Memory side
  input  logic            FlushM,
  output logic            ValidM,
  input  logic            ReadyM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [RW-1:0]   RdM,
  output logic [CW-1:0]   CtrlM,
  output logic [1:0]      CountM,
  output logic [SCW-1:0]  StallCntM
);

  // Encoding chosen so occupancy is the state value itself.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] pc_plus4;
    logic [RW-1:0]   rd;
    logic [CW-1:0]   ctrl;
  } beat_t;

  state_e         state_q, state_d;
  beat_t          main_q, main_d;
  beat_t          skid_q, skid_d;
  logic [SCW-1:0] stall_cnt_q, stall_cnt_d;

  beat_t beat_e;
  logic  up_xfer;
  logic  dn_xfer;

  assign beat_e = '{
    alu_result: ALUResultE,
    write_data: WriteDataE,
    pc_plus4:   PCPlus4E,
    rd:         RdE,
    ctrl:       CtrlE
  };

  // Handshake status decoded purely from registered state.
  assign ReadyE  = (state_q != StFull);
  assign ValidM  = (state_q != StEmpty);
  assign up_xfer = ValidE & ReadyE;
  assign dn_xfer = ValidM & ReadyM;

  // Next-state and entry update.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (FlushM) begin
      // Flush beats every transfer, including a same-cycle ValidE beat.
      state_d = StEmpty;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (up_xfer) begin
            main_d  = beat_e;
            state_d = StOne;
          end
        end
        StOne: begin
          if (up_xfer && dn_xfer) begin
            main_d = beat_e;
          end else if (dn_xfer) begin
            // Main keeps its stale contents; CtrlM is gated below.
            state_d = StEmpty;
          end else if (up_xfer) begin
            // Memory stalled while Execute delivered: park beat in skid.
            skid_d  = beat_e;
            state_d = StFull;
          end
        end
        StFull: begin
          if (ReadyM) begin
            main_d  = skid_q;
            state_d = StOne;
          end
        end
        default: begin
          state_d = StEmpty;
        end
      endcase
    end
  end

  // Back-pressure counter: independent of flush, saturating at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (ValidM && !ReadyM && (stall_cnt_q != {SCW{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + SCW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StEmpty;
      main_q      <= '0;
      skid_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ALUResultM = main_q.alu_result;
  assign WriteDataM = main_q.write_data;
  assign PCPlus4M   = main_q.pc_plus4;
  assign RdM        = main_q.rd;
  // Never expose write enables without a valid beat.
  assign CtrlM      = ValidM ? main_q.ctrl : '0;
  assign CountM     = state_q;
  assign StallCntM  = stall_cnt_q;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
module tb_ex_mem_skid_reg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned CW   = 4;
  localparam int unsigned SCW  = 4;

  typedef struct packed {
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] wd;
    logic [XLEN-1:0] pc;
    logic [RW-1:0]   rd;
    logic [CW-1:0]   ctrl;
  } beat_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            ValidE;
  logic            ReadyE;
  beat_t           b_e;
  logic            FlushM;
  logic            ValidM;
  logic            ReadyM;
  logic [XLEN-1:0] alu_m;
  logic [XLEN-1:0] wd_m;
  logic [XLEN-1:0] pc_m;
  logic [RW-1:0]   rd_m;
  logic [CW-1:0]   ctrl_m;
  logic [1:0]      CountM;
  logic [SCW-1:0]  StallCntM;

  // Reference model: queue of beats held by the block, plus stall counter.
  beat_t exp_q[$];
  int    m_count;
  int    m_stall;
  int    n_tests = 0;
  int    n_fail  = 0;

  always #5 clk = ~clk;

  ex_mem_skid_reg #(
    .XLEN(XLEN),
    .RW  (RW),
    .CW  (CW),
    .SCW (SCW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ValidE    (ValidE),
    .ReadyE    (ReadyE),
    .ALUResultE(b_e.alu),
    .WriteDataE(b_e.wd),
    .PCPlus4E  (b_e.pc),
    .RdE       (b_e.rd),
    .CtrlE     (b_e.ctrl),
    .FlushM    (FlushM),
    .ValidM    (ValidM),
    .ReadyM    (ReadyM),
    .ALUResultM(alu_m),
    .WriteDataM(wd_m),
    .PCPlus4M  (pc_m),
    .RdM       (rd_m),
    .CtrlM     (ctrl_m),
    .CountM    (CountM),
    .StallCntM (StallCntM)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk(input logic [XLEN-1:0] alu, input logic [RW-1:0] rd);
    beat_t b;
    b.alu  = alu;
    b.wd   = alu ^ 32'hA5A5_A5A5;
    b.pc   = alu + 32'd4;
    b.rd   = rd;
    b.ctrl = 4'hB;
    return b;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    b.alu  = $urandom;
    b.wd   = $urandom;
    b.pc   = $urandom;
    b.rd   = 5'($urandom_range(0, 31));
    b.ctrl = 4'($urandom_range(1, 15));
    return b;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_count = 0;
    m_stall = 0;
  endtask

  task automatic check_outputs();
    chk("ValidM", 128'(ValidM), 128'(m_count != 0));
    chk("CountM", 128'(CountM), 128'(m_count));
    chk("ReadyE", 128'(ReadyE), 128'(m_count != 2));
    chk("StallCntM", 128'(StallCntM), 128'(m_stall));
    if (m_count != 0) chk("beat", 128'({alu_m, wd_m, pc_m, rd_m, ctrl_m}), 128'(exp_q[0]));
    else chk("CtrlM_idle", 128'(ctrl_m), 128'(0));
  endtask

  // Advance the model using the inputs present at the coming edge, then
  // clock and check.
  task automatic tick();
    bit up;
    bit dn;
    up = ValidE && (m_count != 2);
    dn = (m_count != 0) && ReadyM;
    if ((m_count != 0) && !ReadyM && (m_stall != 15)) m_stall++;
    if (FlushM) begin
      exp_q.delete();
    end else begin
      if (dn) void'(exp_q.pop_front());
      if (up) exp_q.push_back(b_e);
    end
    m_count = exp_q.size();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // Reset pulse placed between clock edges; checks outputs before next edge.
  task automatic async_reset_pulse();
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    chk("rst_alu", 128'(alu_m), 128'(0));
    chk("rst_rd", 128'(rd_m), 128'(0));
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    FlushM = 1'b0;
    ReadyM = 1'b1;
    ValidE = 1'b1;            // ignored while reset is high
    b_e    = mk(32'hDEAD_BEEF, 5'd3);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    chk("reset_pc", 128'(pc_m), 128'(0));
    chk("reset_wd", 128'(wd_m), 128'(0));
    reset  = 1'b0;
    ValidE = 1'b0;
    tick();

    // Full-throughput stream.
    ReadyM = 1'b1;
    ValidE = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      b_e = mk(32'(i * 16), 5'(i));
      tick();
      chk("stream_alu", 128'(alu_m), 128'(i * 16));
    end
    ValidE = 1'b0;
    tick();
    chk("stream_stall", 128'(StallCntM), 128'(0));

    // Back-pressure: A then B with Memory stalled.
    ReadyM = 1'b0;
    ValidE = 1'b1;
    b_e    = mk(32'h11, 5'd1);
    tick();
    b_e = mk(32'h22, 5'd2);
    tick();
    chk("bp_full_ready", 128'(ReadyE), 128'(0));
    chk("bp_full_alu", 128'(alu_m), 128'(32'h11));
    ValidE = 1'b0;
    tick();
    ReadyM = 1'b1;
    tick();
    chk("bp_second_alu", 128'(alu_m), 128'(32'h22));
    tick();
    chk("bp_empty", 128'(CountM), 128'(0));
    chk("bp_stall", 128'(StallCntM), 128'(2));

    // Flush in FULL with a same-cycle beat targeting Rd 7.
    ReadyM = 1'b0;
    ValidE = 1'b1;
    b_e    = mk(32'h33, 5'd1);
    tick();
    b_e = mk(32'h44, 5'd2);
    tick();
    b_e    = mk(32'h55, 5'd7);
    FlushM = 1'b1;
    tick();
    chk("flush_rd", 128'(rd_m), 128'(0));
    chk("flush_ctrl", 128'(ctrl_m), 128'(0));
    FlushM = 1'b0;
    ValidE = 1'b0;
    ReadyM = 1'b1;
    repeat (3) begin
      tick();
      chk("flush_no_rd7", 128'(rd_m == 5'd7), 128'(0));
    end

    // Asynchronous reset while FULL.
    ReadyM = 1'b0;
    ValidE = 1'b1;
    b_e    = mk(32'h66, 5'd4);
    tick();
    b_e = mk(32'h77, 5'd5);
    tick();
    chk("pre_rst_full", 128'(CountM), 128'(2));
    ValidE = 1'b0;
    async_reset_pulse();
    tick();

    // Stall counter saturation.
    ValidE = 1'b1;
    b_e    = mk(32'h88, 5'd6);
    tick();
    ValidE = 1'b0;
    repeat (20) tick();
    chk("sat_stall", 128'(StallCntM), 128'(15));
    ReadyM = 1'b1;
    tick();
    async_reset_pulse();

    // Random traffic against the scoreboard.
    for (int i = 0; i < 10000; i++) begin
      ValidE = ($urandom_range(0, 9) < 6);
      ReadyM = ($urandom_range(0, 9) < 6);
      FlushM = ($urandom_range(0, 99) < 3);
      b_e    = rand_beat();
      tick();
    end
    ValidE = 1'b0;
    FlushM = 1'b0;
    ReadyM = 1'b1;
    repeat (3) tick();
    chk("drain_empty", 128'(CountM), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid_reg.md
EX_MEM_SKID_REG -- requirements
Module: ex_mem_skid_reg

Interface
REQ-001 Parameter XLEN, default 32: width of ALU result, store data and PC+4 fields.
REQ-002 Parameter RW, default 5: destination register index width.
REQ-003 Parameter CW, default 4: control bundle width (RegWrite, FPRegWrite, MemWrite, ResultSrc bit).
REQ-004 Parameter SCW, default 16: stall counter width.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset; forces reset state immediately, independent of clk.
REQ-007 ValidE  in  1  Execute stage presents a valid instruction.
REQ-008 ReadyE  out  1  block can accept an Execute-stage beat this cycle.
REQ-009 ALUResultE, WriteDataE, PCPlus4E  in  XLEN each  Execute-stage payload.
REQ-010 RdE  in  RW  Execute-stage destination register.
REQ-011 CtrlE  in  CW  Execute-stage control bundle.
REQ-012 FlushM  in  1  synchronous squash of all held beats.
REQ-013 ValidM  out  1  Memory-stage outputs hold a valid beat.
REQ-014 ReadyM  in  1  Memory stage consumes the presented beat.
REQ-015 ALUResultM, WriteDataM, PCPlus4M  out  XLEN; RdM  out  RW; CtrlM  out  CW  Memory-stage payload.
REQ-016 CountM  out  2  occupancy, 0..2.
REQ-017 StallCntM  out  SCW  saturating back-pressure cycle counter.

Function
REQ-018 Storage SHALL be two payload entries: main (drives all *M outputs) and skid.
REQ-019 State machine SHALL have states EMPTY (CountM=0), ONE (1), FULL (2), encoded so CountM equals the state.
REQ-020 ReadyE SHALL be 1 in EMPTY and ONE, 0 in FULL, decoded from registered state only (no combinational path from ReadyM or ValidE).
REQ-021 Upstream transfer occurs iff ValidE & ReadyE; downstream transfer occurs iff ValidM & ReadyM.
REQ-022 ValidM SHALL be 1 in ONE and FULL, 0 in EMPTY.
REQ-023 EMPTY + upstream transfer: load main, go ONE; latency from accepting edge to ValidM = 1 cycle.
REQ-024 ONE + upstream and downstream transfer: load main with new beat, stay ONE (full throughput, one beat per cycle).
REQ-025 ONE + downstream transfer only: go EMPTY; main contents are don't-care but unchanged.
REQ-026 ONE + upstream transfer only (ReadyM=0): load skid, go FULL; main unchanged.
REQ-027 FULL + ReadyM: copy skid to main, go ONE; FULL + !ReadyM: hold.
REQ-028 No transfer: state and entries unchanged.
REQ-029 Beat order SHALL be preserved; no beat dropped or duplicated absent FlushM.
REQ-030 FlushM=1 SHALL take priority over all transfers: next state EMPTY, main and skid payloads cleared to 0, same-cycle ValidE beat discarded.
REQ-031 While ValidM=0, CtrlM SHALL be 0 so no write-enable reaches Memory/Writeback.
REQ-032 StallCntM SHALL increment by 1 each cycle with ValidM & !ReadyM, saturating at 2^SCW-1; not cleared by FlushM.
REQ-033 Payload fields SHALL be passed bit-exact; no arithmetic on data.

Reset
REQ-034 On reset: state EMPTY, ValidM=0, CountM=0, ReadyE=1, StallCntM=0, all payload outputs and skid entry 0.
REQ-035 Reset asserted mid-operation (ONE or FULL) SHALL discard all held beats immediately; first post-reset beat is the next ValidE accepted after deassertion.
REQ-036 Inputs SHALL be ignored while reset=1.

Verification
REQ-037 Stream: ReadyM=1, ValidE=1 for 4 cycles, ALUResultE=0x10,0x20,0x30,0x40 -> ALUResultM shows same sequence one cycle later, ValidM=1 each, CountM=1, StallCntM=0.
REQ-038 Back-pressure: beats A=0x11, B=0x22 with ReadyM=0 -> FULL, ReadyE=0, ALUResultM=0x11; raise ReadyM -> 0x11 then 0x22 presented, returns to EMPTY; StallCntM equals stalled cycles.
REQ-039 Flush in FULL with ValidE=1, RdE=7 -> next cycle ValidM=0, CountM=0, CtrlM=0, RdM=0; Rd 7 never appears.
REQ-040 Async reset pulse between clock edges in FULL -> outputs zero before next clk edge; ReadyE=1.
REQ-041 Saturation with SCW=4: ReadyM=0, ValidM=1 for 20 cycles -> StallCntM sticks at 0xF.
REQ-042 Random ValidE/ReadyM/FlushM for 10k cycles vs. scoreboard -> in-order, loss-free delivery except flushed beats; ReadyE never 1 in FULL.
